// File: rtl/hsv_core_branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_branch_resolve_if
// Description : Bundle between the execute issue side and the branch
//               resolution stage: resolve request, commit record and the
//               predictor-update handshake toward fetch.
//               out_action encoding: 0 = COMMIT_NEXT, 1 = COMMIT_JUMP,
//               2 = COMMIT_EXCEPTION.
// Modports    : slave  - the resolution stage (consumes requests, drives
//                        records and updates)
//               master - the surrounding core / bench
// Revision    : 1.0 - initial release
// ============================================================================
interface hsv_core_branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 64
);
  // Resolve request
  logic              valid_i;
  logic [TAG_W-1:0]  in_tag;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_pc_increment;
  logic [XLEN-1:0]   in_predicted;
  logic [XLEN-1:0]   in_target;
  logic              in_taken;
  logic              in_link;
  logic              in_cond;
  // Commit record
  logic              valid_o;
  logic [1:0]        out_action;
  logic [TAG_W-1:0]  out_tag;
  logic [XLEN-1:0]   out_result;
  logic [XLEN-1:0]   out_next_pc;
  logic              out_writeback;
  // Predictor update
  logic              upd_valid;
  logic              upd_ready;
  logic [XLEN-1:0]   upd_pc;
  logic [XLEN-1:0]   upd_target;
  logic              upd_taken;
  logic              upd_cond;
  logic              upd_mispredict;
  logic              upd_dropped;

  modport slave (
    input  valid_i, in_tag, in_pc, in_pc_increment, in_predicted, in_target,
           in_taken, in_link, in_cond, upd_ready,
    output valid_o, out_action, out_tag, out_result, out_next_pc, out_writeback,
           upd_valid, upd_pc, upd_target, upd_taken, upd_cond, upd_mispredict,
           upd_dropped
  );

  modport master (
    output valid_i, in_tag, in_pc, in_pc_increment, in_predicted, in_target,
           in_taken, in_link, in_cond, upd_ready,
    input  valid_o, out_action, out_tag, out_result, out_next_pc, out_writeback,
           upd_valid, upd_pc, upd_target, upd_taken, upd_cond, upd_mispredict,
           upd_dropped
  );
endinterface
`default_nettype wire

// File: rtl/hsv_core_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_branch_resolve
// Description : Branch/jump resolution stage. Resolves the final PC, flags
//               mispredicts and misaligned targets, carries a commit record
//               through LATENCY register stages and queues predictor-training
//               updates in a small FIFO.
// Ports       : clk_core, rst_core (async, active-high), stall, flush_req,
//               bif (hsv_core_branch_resolve_if.slave): request, record and
//               update handshake.
//               perf_branches / perf_mispredicts only when HSV_BRANCH_PERF_EN
//               is defined.
// Options     : HSV_BRANCH_PERF_EN - saturating branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_branch_resolve #(
  parameter int XLEN      = 32,
  parameter int IALIGN    = 32,
  parameter int LATENCY   = 1,
  parameter int TAG_W     = 64,
  parameter int UPD_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic                            clk_core,
  input  logic                            rst_core,
  input  logic                            stall,
  input  logic                            flush_req,
  hsv_core_branch_resolve_if.slave        bif
`ifdef HSV_BRANCH_PERF_EN
  ,
  output logic [CNT_W-1:0]                perf_branches,
  output logic [CNT_W-1:0]                perf_mispredicts
`endif
);
  localparam logic [1:0] c_commit_next      = 2'd0;
  localparam logic [1:0] c_commit_jump      = 2'd1;
  localparam logic [1:0] c_commit_exception = 2'd2;
  localparam int         c_ofs_w            = $clog2(IALIGN / 8);
  localparam int         c_aw               = $clog2(UPD_DEPTH);
  localparam int         c_last             = LATENCY - 1;
  localparam logic [c_aw:0] c_ptr_one       = 1;

  // ---------------------------------------------------------------- resolve
  logic [XLEN-1:0] w_final_pc;
  logic            w_mispredict;
  logic            w_misaligned;
  logic [1:0]      w_action;

  always_comb begin
    w_final_pc   = bif.in_taken ? bif.in_target : bif.in_pc_increment;
    w_mispredict = (w_final_pc != bif.in_predicted);
    w_misaligned = bif.in_taken & (bif.in_target[c_ofs_w-1:0] != '0);
    w_action     = c_commit_next;
    if (w_misaligned)      w_action = c_commit_exception;
    else if (w_mispredict) w_action = c_commit_jump;
  end

  // --------------------------------------------------------------- pipeline
  // Besides the visible record, each stage carries pc/taken/cond so the
  // update entry can be built when the record is accepted at the output.
  logic             r_vld   [LATENCY];
  logic [1:0]       r_act   [LATENCY];
  logic [TAG_W-1:0] r_tag   [LATENCY];
  logic [XLEN-1:0]  r_res   [LATENCY];
  logic [XLEN-1:0]  r_npc   [LATENCY];
  logic [XLEN-1:0]  r_pc    [LATENCY];
  logic             r_wb    [LATENCY];
  logic             r_taken [LATENCY];
  logic             r_cond  [LATENCY];

  // Flush beats stall and beats the incoming request.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      for (int i = 0; i < LATENCY; i++) r_vld[i] <= 1'b0;
    end else if (flush_req) begin
      for (int i = 0; i < LATENCY; i++) r_vld[i] <= 1'b0;
    end else if (!stall) begin
      r_vld[0] <= bif.valid_i;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_act[i]   <= c_commit_next;
        r_tag[i]   <= '0;
        r_res[i]   <= '0;
        r_npc[i]   <= '0;
        r_pc[i]    <= '0;
        r_wb[i]    <= 1'b0;
        r_taken[i] <= 1'b0;
        r_cond[i]  <= 1'b0;
      end
    end else if (!stall) begin
      r_act[0]   <= w_action;
      r_tag[0]   <= bif.in_tag;
      r_res[0]   <= bif.in_pc_increment;
      r_npc[0]   <= w_final_pc;
      r_pc[0]    <= bif.in_pc;
      r_wb[0]    <= bif.in_link;
      r_taken[0] <= bif.in_taken;
      r_cond[0]  <= bif.in_cond;
      for (int i = 1; i < LATENCY; i++) begin
        r_act[i]   <= r_act[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_res[i]   <= r_res[i-1];
        r_npc[i]   <= r_npc[i-1];
        r_pc[i]    <= r_pc[i-1];
        r_wb[i]    <= r_wb[i-1];
        r_taken[i] <= r_taken[i-1];
        r_cond[i]  <= r_cond[i-1];
      end
    end
  end

  assign bif.valid_o       = r_vld[c_last];
  assign bif.out_action    = r_act[c_last];
  assign bif.out_tag       = r_tag[c_last];
  assign bif.out_result    = r_res[c_last];
  assign bif.out_next_pc   = r_npc[c_last];
  assign bif.out_writeback = r_wb[c_last];

  // ------------------------------------------------------- predictor update
  logic w_accept;
  logic w_push;
  logic w_push_ok;
  logic w_pop;
  logic w_full;
  logic w_empty;

  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [XLEN-1:0] r_f_pc     [UPD_DEPTH];
  logic [XLEN-1:0] r_f_tgt    [UPD_DEPTH];
  logic            r_f_taken  [UPD_DEPTH];
  logic            r_f_cond   [UPD_DEPTH];
  logic            r_f_misp   [UPD_DEPTH];
  logic            r_dropped;

  assign w_accept  = r_vld[c_last] & ~stall & ~flush_req;
  assign w_push    = w_accept & (r_act[c_last] != c_commit_exception)
                   & (r_cond[c_last] | r_taken[c_last]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_pop     = ~w_empty & bif.upd_ready;
  // When full, a same-cycle pop frees exactly the slot the push writes.
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_dropped <= 1'b0;
      for (int i = 0; i < UPD_DEPTH; i++) begin
        r_f_pc[i]    <= '0;
        r_f_tgt[i]   <= '0;
        r_f_taken[i] <= 1'b0;
        r_f_cond[i]  <= 1'b0;
        r_f_misp[i]  <= 1'b0;
      end
    end else begin
      r_dropped <= w_push & ~w_push_ok;
      if (w_push_ok) begin
        r_f_pc[r_wr_ptr[c_aw-1:0]]    <= r_pc[c_last];
        r_f_tgt[r_wr_ptr[c_aw-1:0]]   <= r_npc[c_last];
        r_f_taken[r_wr_ptr[c_aw-1:0]] <= r_taken[c_last];
        r_f_cond[r_wr_ptr[c_aw-1:0]]  <= r_cond[c_last];
        r_f_misp[r_wr_ptr[c_aw-1:0]]  <= (r_act[c_last] == c_commit_jump);
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  assign bif.upd_valid      = ~w_empty;
  assign bif.upd_pc         = r_f_pc[r_rd_ptr[c_aw-1:0]];
  assign bif.upd_target     = r_f_tgt[r_rd_ptr[c_aw-1:0]];
  assign bif.upd_taken      = r_f_taken[r_rd_ptr[c_aw-1:0]];
  assign bif.upd_cond       = r_f_cond[r_rd_ptr[c_aw-1:0]];
  assign bif.upd_mispredict = r_f_misp[r_rd_ptr[c_aw-1:0]];
  assign bif.upd_dropped    = r_dropped;

  // ----------------------------------------------------- perf counters
`ifdef HSV_BRANCH_PERF_EN
  localparam logic [CNT_W-1:0] c_cnt_one = 1;
  logic [CNT_W-1:0] r_perf_br;
  logic [CNT_W-1:0] r_perf_mp;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else begin
      if (w_accept && r_cond[c_last] && !(&r_perf_br))
        r_perf_br <= r_perf_br + c_cnt_one;
      if (w_accept && (r_act[c_last] == c_commit_jump) && !(&r_perf_mp))
        r_perf_mp <= r_perf_mp + c_cnt_one;
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mp;
`else
  // Counters compiled out: no perf state or ports.
`endif
endmodule
`default_nettype wire
